// File: rtl/pong_collision_engine_pkg.sv
// Shared codes, bit indices and FSM states
// for the pong collision engine.
package pong_collision_engine_pkg;

  localparam logic [2:0] COL_NONE   = 3'd0;
  localparam logic [2:0] COL_TOP    = 3'd1;
  localparam logic [2:0] COL_BOTTOM = 3'd2;
  localparam logic [2:0] COL_PAD_L  = 3'd3;
  localparam logic [2:0] COL_PAD_R  = 3'd4;
  localparam logic [2:0] COL_MISS_L = 3'd5;
  localparam logic [2:0] COL_MISS_R = 3'd6;

  localparam int FLAG_TOP    = 0;
  localparam int FLAG_BOTTOM = 1;
  localparam int FLAG_PAD    = 2;
  localparam int FLAG_MISS   = 3;

  localparam int WALL_TOP    = 0;
  localparam int WALL_BOTTOM = 1;
  localparam int WALL_LEFT   = 2;
  localparam int WALL_RIGHT  = 3;

  localparam int SRC_TOP    = 0;
  localparam int SRC_BOTTOM = 1;
  localparam int SRC_PAD_L  = 2;
  localparam int SRC_PAD_R  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_EVAL,
    ST_MISS,
    ST_OVER
  } state_t;

endpackage

// File: rtl/pong_hit_detector.sv
// Pure comparison logic: ball box against one
// paddle box, or against the four screen edges.
import pong_collision_engine_pkg::*;

module pong_hit_detector #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int BALL_SZ  = 8,
  parameter int OBJ_X    = 16,
  parameter int OBJ_W    = 8,
  parameter int OBJ_H    = 64,
  parameter bit WALLS    = 1'b0
) (
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] obj_y,
  output logic [3:0] hit
);

  logic [10:0] bx_lo;
  logic [10:0] by_lo;
  logic [10:0] bx_hi;
  logic [10:0] by_hi;
  logic [10:0] oy_lo;
  logic [10:0] oy_hi;

  // Edge or box-overlap tests, sums kept in 11 bits
  always_comb begin
    bx_lo = {1'b0, ball_x};
    by_lo = {1'b0, ball_y};
    bx_hi = bx_lo + 11'(BALL_SZ);
    by_hi = by_lo + 11'(BALL_SZ);
    oy_lo = {1'b0, obj_y};
    oy_hi = oy_lo + 11'(OBJ_H);
    hit   = '0;
    if (WALLS) begin
      hit[WALL_TOP]    = (ball_y == 10'd0);
      hit[WALL_BOTTOM] = (by_hi >= 11'(SCREEN_H));
      hit[WALL_LEFT]   = (ball_x == 10'd0);
      hit[WALL_RIGHT]  = (bx_hi >= 11'(SCREEN_W));
    end else begin
      hit[0] = (bx_lo < 11'(OBJ_X + OBJ_W)) &&
               (bx_hi > 11'(OBJ_X)) &&
               (by_hi > oy_lo) &&
               (by_lo < oy_hi);
    end
  end

endmodule

// File: rtl/pong_collision_engine.sv
// Per-frame collision, lives and speed engine
// for PONG with one or two paddles.
import pong_collision_engine_pkg::*;

module pong_collision_engine #(
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int BALL_SZ       = 8,
  parameter int PAD_W         = 8,
  parameter int PAD_H         = 64,
  parameter int PAD_X0        = 16,
  parameter int N_PADDLES     = 1,
  parameter int LIVES         = 3,
  parameter int SPD_MIN       = 2,
  parameter int SPD_MAX       = 8,
  parameter int HITS_PER_STEP = 4
) (
  input  logic                     Clk_100MHz,
  input  logic                     Reset,
  input  logic                     FrameTick,
  input  logic                     GameEnable,
  input  logic                     LivesCountReset,
  input  logic                     Sw2,
  input  logic [10*N_PADDLES-1:0]  paddlePosY,
  input  logic [9:0]               ballPosX,
  input  logic [9:0]               ballPosY,
  output logic [2:0]               ColOut,
  output logic [3:0]               ColFlags,
  output logic                     ColValid,
  output logic [9:0]               ballSpeed,
  output logic [3*N_PADDLES-1:0]   LivesCount,
  output logic                     ballPosReset,
  output logic                     GameOver
);

  localparam int PAD_R_X = SCREEN_W - PAD_X0 - PAD_W;
  localparam bit TWO     = (N_PADDLES == 2);

  state_t state;
  state_t state_nx;

  logic [3:0] wall_hit;
  logic [3:0] pad_l_vec;
  logic       pad_l;
  logic       pad_r;
  logic       miss_l;
  logic       miss_r;
  logic       miss;
  logic       pad_hit;
  logic       eval_go;
  logic       dead;
  logic [3:0] now;
  logic [3:0] fresh;
  logic [3:0] contact;
  logic [3:0] flags;
  logic [2:0] code;
  logic [7:0] hit_cnt;

  logic [N_PADDLES-1:0][2:0] lives;
  logic [N_PADDLES-1:0][2:0] lives_nx;

  pong_hit_detector #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .BALL_SZ  (BALL_SZ),
    .OBJ_X    (0),
    .OBJ_W    (0),
    .OBJ_H    (0),
    .WALLS    (1'b1)
  ) u_walls (
    .ball_x (ballPosX),
    .ball_y (ballPosY),
    .obj_y  (10'd0),
    .hit    (wall_hit)
  );

  pong_hit_detector #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .BALL_SZ  (BALL_SZ),
    .OBJ_X    (PAD_X0),
    .OBJ_W    (PAD_W),
    .OBJ_H    (PAD_H),
    .WALLS    (1'b0)
  ) u_pad_l (
    .ball_x (ballPosX),
    .ball_y (ballPosY),
    .obj_y  (paddlePosY[9:0]),
    .hit    (pad_l_vec)
  );

  assign pad_l  = |pad_l_vec;
  // A paddle covering the goal line saves the ball
  assign miss_l = wall_hit[WALL_LEFT] & ~pad_l;

  if (TWO) begin : g_two
    logic [3:0] pad_r_vec;
    pong_hit_detector #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .BALL_SZ  (BALL_SZ),
      .OBJ_X    (PAD_R_X),
      .OBJ_W    (PAD_W),
      .OBJ_H    (PAD_H),
      .WALLS    (1'b0)
    ) u_pad_r (
      .ball_x (ballPosX),
      .ball_y (ballPosY),
      .obj_y  (paddlePosY[10*N_PADDLES-1:10]),
      .hit    (pad_r_vec)
    );
    assign pad_r  = |pad_r_vec;
    assign miss_r = wall_hit[WALL_RIGHT] & ~pad_r;
  end else begin : g_one
    assign pad_r  = wall_hit[WALL_RIGHT];
    assign miss_r = 1'b0;
  end

  // Contact sources, first-frame filtering and code priority
  always_comb begin
    now = '0;
    now[SRC_TOP]    = wall_hit[WALL_TOP];
    now[SRC_BOTTOM] = wall_hit[WALL_BOTTOM];
    now[SRC_PAD_L]  = pad_l;
    now[SRC_PAD_R]  = pad_r;
    fresh = now & ~contact;
    miss  = miss_l | miss_r;
    pad_hit = fresh[SRC_PAD_L] |
              (TWO & fresh[SRC_PAD_R]);
    flags = '0;
    flags[FLAG_MISS]   = miss;
    flags[FLAG_PAD]    = fresh[SRC_PAD_L] |
                         fresh[SRC_PAD_R];
    flags[FLAG_BOTTOM] = fresh[SRC_BOTTOM];
    flags[FLAG_TOP]    = fresh[SRC_TOP];
    code = COL_NONE;
    priority case (1'b1)
      miss_l:            code = COL_MISS_L;
      miss_r:            code = COL_MISS_R;
      fresh[SRC_PAD_L]:  code = COL_PAD_L;
      fresh[SRC_PAD_R]:  code = COL_PAD_R;
      fresh[SRC_BOTTOM]: code = COL_BOTTOM;
      fresh[SRC_TOP]:    code = COL_TOP;
      default:           code = COL_NONE;
    endcase
  end

  // Lives after a miss, and whether any player is out
  always_comb begin
    lives_nx = lives;
    dead     = 1'b0;
    if (miss_l && lives[0] != 3'd0)
      lives_nx[0] = lives[0] - 3'd1;
    if (miss_r && lives[N_PADDLES-1] != 3'd0)
      lives_nx[N_PADDLES-1] =
        lives[N_PADDLES-1] - 3'd1;
    for (int i = 0; i < N_PADDLES; i++)
      if (lives[i] == 3'd0) dead = 1'b1;
  end

  assign eval_go = (state == ST_PLAY) && FrameTick &&
                   GameEnable && !LivesCountReset;

  // State register
  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (LivesCountReset) begin
      state_nx = ST_IDLE;
    end else if (!GameEnable && state != ST_OVER) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: state_nx = ST_PLAY;
        ST_PLAY: if (FrameTick) state_nx = ST_EVAL;
        ST_EVAL: begin
          if (!ColFlags[FLAG_MISS]) state_nx = ST_PLAY;
          else if (dead)            state_nx = ST_OVER;
          else                      state_nx = ST_MISS;
        end
        ST_MISS: if (FrameTick) state_nx = ST_PLAY;
        ST_OVER: state_nx = ST_OVER;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Registered results, lives, speed ramp and pulses
  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      ColOut       <= COL_NONE;
      ColFlags     <= '0;
      ColValid     <= 1'b0;
      ballSpeed    <= 10'(SPD_MIN);
      lives        <= {N_PADDLES{3'(LIVES)}};
      ballPosReset <= 1'b0;
      GameOver     <= 1'b0;
      hit_cnt      <= '0;
      contact      <= '0;
    end else begin
      ColValid     <= 1'b0;
      ballPosReset <= 1'b0;
      if (LivesCountReset) begin
        lives     <= {N_PADDLES{3'(LIVES)}};
        ballSpeed <= 10'(SPD_MIN);
        hit_cnt   <= '0;
        contact   <= '0;
        GameOver  <= 1'b0;
      end else begin
        if (!Sw2) begin
          ballSpeed <= 10'(SPD_MIN);
          hit_cnt   <= '0;
        end
        if (eval_go) begin
          ColOut   <= code;
          ColFlags <= flags;
          ColValid <= 1'b1;
          contact  <= now;
          if (miss) begin
            lives     <= lives_nx;
            ballSpeed <= 10'(SPD_MIN);
            hit_cnt   <= '0;
          end else if (Sw2 && pad_hit) begin
            if (hit_cnt == 8'(HITS_PER_STEP - 1)) begin
              hit_cnt <= '0;
              if (ballSpeed < 10'(SPD_MAX))
                ballSpeed <= ballSpeed + 10'd1;
            end else begin
              hit_cnt <= hit_cnt + 8'd1;
            end
          end
        end
        if (state == ST_EVAL && state_nx == ST_MISS)
          ballPosReset <= 1'b1;
        if (state == ST_EVAL && state_nx == ST_OVER)
          GameOver <= 1'b1;
      end
    end
  end

  assign LivesCount = lives;

endmodule
